// File: rtl/dflop_checker.sv
// Response checker for a WIDTH-bit D flip-flop: compares Y against the D
// sampled on the previous edge, counts mismatches and records the first one.
module dflop_checker #(
    parameter int WIDTH      = 4,
    parameter int NUM_CHECKS = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] exp_val;
    logic             mismatch;
    logic [CNT_W-1:0] err_next;
    logic [CNT_W-1:0] chk_next;
    logic             last_chk;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        mismatch = (Y != exp_val);
        err_next = mismatch ? sat_inc(err_cnt) : err_cnt;
        chk_next = chk_cnt + 1'b1;
        last_chk = (chk_next == CNT_W'(NUM_CHECKS));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            exp_val         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            chk_cnt         <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
            first_err_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state           <= CHECK;
                        exp_val         <= D;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        chk_cnt         <= '0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        first_err_exp   <= '0;
                        first_err_got   <= '0;
                        first_err_idx   <= '0;
                    end
                end
                CHECK: begin
                    // Dropping en aborts without comparing on this edge.
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        err_cnt <= err_next;
                        chk_cnt <= chk_next;
                        exp_val <= D;
                        if (mismatch && !first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_exp   <= exp_val;
                            first_err_got   <= Y;
                            first_err_idx   <= chk_cnt;
                        end
                        if (last_chk) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end
                    end
                end
                DONE: begin
                    // Results are held; en must fall before a new run can start.
                    if (!en) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule
